// File: rtl/serial_comp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state
// encoding, {lt,eq,gt} result codes and the bit-counter width helper.
package serial_comp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Result codes packed as {lt, eq, gt}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;

    // Counter width max(1, clog2(w)); a 1- or 2-bit operand still needs one bit
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bit_comp_cell.sv
// Single-bit magnitude compare cell: purely combinational, one-hot outputs.
module bit_comp_cell (
    input  logic a_i,
    input  logic b_i,
    output logic lt_o,
    output logic eq_o,
    output logic gt_o
);

    // One-hot relation between the two input bits
    always_comb begin
        lt_o = ~a_i &  b_i;
        gt_o =  a_i & ~b_i;
        eq_o = ~(a_i ^ b_i);
    end

endmodule

// File: rtl/serial_comp_ctrl.sv
// Serial MSB-first magnitude comparator built around one bit_comp_cell.
// Handshake: start accepted in IDLE or DONE, busy during SHIFT, done is a
// one-cycle pulse in DONE, lt/eq/gt are registered and held between dones.
// Build option SERIAL_COMP_EARLY_EXIT_EN: when defined, SHIFT ends on the
// first differing bit; otherwise every compare runs all WIDTH bits and the
// first difference is held in a sticky flag so the result is the same.
module serial_comp_ctrl
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       res_q, res_d;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
    logic             seen_q, seen_d;   // a differing bit has already been found
    logic             sgt_q, sgt_d;     // that first difference had a=1, b=0
`endif

    logic cell_lt, cell_eq, cell_gt;

    bit_comp_cell u_cell (
        .a_i  (a_sr_q[WIDTH-1]),
        .b_i  (b_sr_q[WIDTH-1]),
        .lt_o (cell_lt),
        .eq_o (cell_eq),
        .gt_o (cell_gt)
    );

    // State, operand shift registers, counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            cnt_q   <= '0;
            res_q   <= RES_NONE;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
            seen_q  <= 1'b0;
            sgt_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
            seen_q  <= seen_d;
            sgt_q   <= sgt_d;
`endif
        end
    end

    // Next-state logic: capture on accept, shift one bit per SHIFT cycle,
    // write the result only on the transition into DONE
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
        seen_d  = seen_q;
        sgt_d   = sgt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    cnt_d   = CW'(WIDTH - 1);
`ifndef SERIAL_COMP_EARLY_EXIT_EN
                    seen_d  = 1'b0;
                    sgt_d   = 1'b0;
`endif
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d = a_sr_q << 1;
                b_sr_d = b_sr_q << 1;
                cnt_d  = cnt_q - CW'(1);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
                if (!cell_eq) begin
                    res_d   = {cell_lt, 1'b0, cell_gt};
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    res_d   = RES_EQ;
                    state_d = DONE;
                end
`else
                if (!seen_q && !cell_eq) begin
                    seen_d = 1'b1;
                    sgt_d  = cell_gt;
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (seen_q)
                        res_d = sgt_q ? RES_GT : RES_LT;
                    else if (!cell_eq)
                        res_d = {cell_lt, 1'b0, cell_gt};
                    else
                        res_d = RES_EQ;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Status decoded straight from state; results straight from registers
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        lt   = res_q[2];
        eq   = res_q[1];
        gt   = res_q[0];
    end

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Testbench for serial_comp_ctrl (WIDTH=8): directed table, handshake
// corner sequences and randomized compares against a reference model.
module tb_serial_comp_ctrl;

    localparam int W = 8;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done, lt, eq, gt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_comp_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   res;   // {lt,eq,gt}
        int           lat;   // edges after accept until done is seen
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a < b) return 3'b100;
        if (a > b) return 3'b001;
        return 3'b010;
    endfunction

    function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        x = a ^ b;
        if (!EE) return W;
        for (int i = W - 1; i >= 0; i--)
            if (x[i]) return W - i;
        return W;
    endfunction

    function automatic int res_now();
        return int'({lt, eq, gt});
    endfunction

    // Present operands with start for one edge; returns just after the accept edge
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
    endtask

    // Count edges until done is seen (bounded); busy must stay high before it
    task automatic wait_done(input string name, output int lat);
        bit busy_bad;
        busy_bad = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
        end
        chk({name, "_busy_before_done"}, int'(busy_bad), 0);
    endtask

    task automatic check_done(input string name, input int lat, input int exp_lat,
                              input logic [2:0] exp_res);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_result"}, res_now(), int'(exp_res));
        chk({name, "_busy_at_done"}, int'(busy), 0);
    endtask

    // One cycle after DONE with start low: back to idle, result held
    task automatic check_after(input string name, input logic [2:0] exp_res);
        @(posedge clk);
        #1;
        chk({name, "_done_pulse_width"}, int'(done), 0);
        chk({name, "_idle_busy"}, int'(busy), 0);
        chk({name, "_result_held"}, res_now(), int'(exp_res));
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat2, n;
        logic [W-1:0] ra, rb;

        vecs[0] = '{8'hA5, 8'hA5, 3'b010, 8};
        vecs[1] = '{8'h80, 8'h7F, 3'b001, EE ? 1 : 8};
        vecs[2] = '{8'h10, 8'h11, 3'b100, 8};
        vecs[3] = '{8'h00, 8'h00, 3'b010, 8};
        vecs[4] = '{8'hFF, 8'hFE, 3'b001, 8};
        vecs[5] = '{8'h3C, 8'h4C, 3'b100, EE ? 2 : 8};
        vecs[6] = '{8'h7F, 8'h80, 3'b100, EE ? 1 : 8};
        vecs[7] = '{8'hFF, 8'h00, 3'b001, EE ? 1 : 8};
        vecs[8] = '{8'h01, 8'h02, 3'b100, EE ? 7 : 8};

        // Reset state and quiet idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", res_now(), 0);
        count_dones(20, n);
        chk("idle_no_done", n, 0);
        chk("idle_result_zero", res_now(), 0);

        // Directed table
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), lat);
            check_done($sformatf("vec%0d", i), lat, vecs[i].lat, vecs[i].res);
            check_after($sformatf("vec%0d", i), vecs[i].res);
        end

        // Back-to-back: start held through DONE, no IDLE gap
        start_op(8'h01, 8'h02);
        wait_done("b2b_first", lat);
        check_done("b2b_first", lat, EE ? 7 : 8, 3'b100);
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'hFF;
        chk("b2b_no_gap_busy", int'(busy), EE ? 1 : 1);
        chk("b2b_first_result_held", res_now(), 3'b100);
        wait_done("b2b_second", lat2);
        check_done("b2b_second", lat2, EE ? 1 : 8, 3'b001);
        check_after("b2b_second", 3'b001);

        // start pulsed during SHIFT is ignored
        start_op(8'h10, 8'h11);
        @(posedge clk);
        #1;
        chk("ign_done_early", int'(done), 0);
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'h00;
        b_in  = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_still_busy", int'(busy), 1);
        wait_done("ign", lat);
        check_done("ign", lat + 2, 8, 3'b100);
        check_after("ign", 3'b100);
        count_dones(12, n);
        chk("ign_no_extra_done", n, 0);

        // Reset in the middle of a compare
        start_op(8'h12, 8'h13);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_result", res_now(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        count_dones(12, n);
        chk("midrst_no_done", n, 0);
        start_op(8'h33, 8'h33);
        wait_done("after_rst", lat);
        check_done("after_rst", lat, 8, 3'b010);
        check_after("after_rst", 3'b010);

        // Randomized compares against the reference model
        for (int t = 0; t < 40; t++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            start_op(ra, rb);
            wait_done($sformatf("rand%0d", t), lat);
            check_done($sformatf("rand%0d", t), lat, model_lat(ra, rb), model_res(ra, rb));
            check_after($sformatf("rand%0d", t), model_res(ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_comp_ctrl.md
Name: serial_comp_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands MSB-first, one bit per clock, through a single 1-bit comparator cell.
- Wraps the team's single-bit compare datapath. Adds start/done handshake, operand capture, a bit counter and registered lt/eq/gt results.
- Serves multi-bit magnitude compares where area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only on a rising edge where busy=0
- a_in  input  WIDTH  operand A; sampled on the accepting edge only
- b_in  input  WIDTH  operand B; sampled on the accepting edge only
- busy  output  1  high while the compare is in progress (state SHIFT)
- done  output  1  one-cycle pulse; the results are valid and freshly updated
- lt  output  1  A < B
- eq  output  1  A == B
- gt  output  1  A > B

Behaviour:
- Reset (async, asserted): state=IDLE; busy, done, lt, eq, gt all 0; shift registers and counter cleared. A reset mid-compare aborts with no done pulse.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - start=1 captures a_in/b_in into the shift registers and loads cnt=WIDTH-1.
  - Next state is SHIFT.
- SHIFT:
  - Each edge feeds the current MSBs of both shift registers to the cell, then shifts both registers left by 1 and decrements cnt.
  - If the cell reports a<b or a>b: set lt/gt, clear eq, go to DONE (early exit, see Optional Feature).
  - If the bits are equal and cnt==0: set eq=1, clear lt/gt, go to DONE.
  - start is ignored while in SHIFT.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 in this cycle is accepted, with the same capture as IDLE and next state SHIFT (back-to-back compares).
  - Otherwise the next state is IDLE.
- Outputs:
  - busy is combinational from state (state==SHIFT).
  - done is combinational from state (state==DONE).
  - lt/eq/gt are registers, written only on the edge that enters DONE, and held until the next such edge.
  - Exactly one of lt/eq/gt is 1 after the first done; all are 0 before it.
- Latency, with the accepting edge as E0:
  - Full scan: done is high in the cycle after edge E0+WIDTH.
  - Early exit at the first differing bit k (MSB=WIDTH-1): done is high after edge E0+(WIDTH-k).
- Operand inputs may change freely while busy without affecting the result.
- WIDTH=1: one SHIFT cycle. The counter width is max(1,clog2(WIDTH)).

Optional Feature:
- Macro: SERIAL_COMP_EARLY_EXIT_EN.
- Defined: SHIFT leaves for DONE on the first differing bit. Latency is data-dependent (1..WIDTH SHIFT cycles).
- Undefined:
  - SHIFT always runs all WIDTH cycles.
  - The first differing bit is latched into a sticky result.
  - Later bits do not change that sticky result.
  - Latency is fixed at WIDTH SHIFT cycles, so done always lands at E0+WIDTH.
- The lt/eq/gt values are identical in both builds.

Decomposition:
- Package serial_comp_pkg:
  - state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - result-code constants for lt/eq/gt;
  - a counter-width function max(1,clog2(w)).
- One sub-module, bit_comp_cell: purely combinational 1-bit compare (a,b -> lt,eq,gt), instantiated once.

Test Plan (WIDTH=8):
- Reset: rst=1 for 2 cycles, then released → busy=0, done=0, lt=eq=gt=0; done stays 0 with start=0 for 20 cycles.
- Equal operands: start with a_in=8'hA5, b_in=8'hA5 → busy for 8 cycles; done pulses 1 cycle at E0+8; eq=1, lt=gt=0, held afterward.
- MSB differs: a_in=8'h80, b_in=8'h7F →
  - gt=1;
  - with EN, done at E0+1;
  - without EN, done at E0+8 and gt remains 1 (later bits ignored).
- LSB differs: a_in=8'h10, b_in=8'h11 → lt=1, done at E0+8 in both builds.
- Back-to-back: first compare 8'h01 vs 8'h02; start held high through its DONE cycle with 8'hFF vs 8'h00 → second compare starts with no IDLE gap; results are lt then gt; start pulses during busy are ignored (no extra done).
- Reset mid-op: rst asserted at E0+3 of a compare, released, new start with 8'h33 vs 8'h33 → no done for the aborted compare; the new compare completes with eq=1.
